// File: rtl/boton_acondicionador_pkg.sv
// boton_acondicionador_pkg: shared channel FSM states and default timing constants
package boton_acondicionador_pkg;
  typedef enum logic [1:0] {
    SUELTO     = 2'd0,
    PRESIONADO = 2'd1,
    SOSTENIDO  = 2'd2
  } estado_t;
  localparam int NUM_BOTONES_DEF   = 3;
  localparam int CICLOS_POR_MS_DEF = 50000;
  localparam int DEBOUNCE_MS_DEF   = 20;
  localparam int HOLD_MS_DEF       = 5000;
endpackage

// File: rtl/boton_acondicionador_canal.sv
// boton_canal: synchronizer, debounce and short/long press classifier for one button
module boton_canal
  import boton_acondicionador_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF,
  parameter int HOLD_MS     = HOLD_MS_DEF,
  parameter bit ACTIVO_BAJO = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic boton_i,
  output logic nivel_o,
  output logic corto_o,
  output logic largo_o
);
  localparam int DW = $clog2(DEBOUNCE_MS) + 1;
  localparam int HW = $clog2(HOLD_MS) + 1;
  logic [1:0] sync_q;
  logic estable_q, estable_d, corto_q, corto_d, largo_q, largo_d;
  logic cambio, deb_fin, hold_fin;
  logic [DW-1:0] deb_q, deb_d;
  logic [HW-1:0] hold_q, hold_d;
  estado_t estado_q, estado_d;
  assign cambio   = sync_q[1] != estable_q;
  assign deb_fin  = tick_i && deb_q == DW'(DEBOUNCE_MS - 1);
  assign hold_fin = tick_i && hold_q == HW'(HOLD_MS - 1);
  always_comb begin
    estable_d = estable_q ^ (cambio && deb_fin);
    deb_d     = (!cambio || deb_fin) ? '0 : deb_q + DW'(tick_i);
  end
  // a fall coinciding with the hold threshold still counts as a long press
  always_comb begin
    estado_d = estado_q;
    hold_d   = hold_q;
    corto_d  = 1'b0;
    largo_d  = 1'b0;
    case (estado_q)
      SUELTO: begin
        estado_d = estable_q ? PRESIONADO : SUELTO;
        hold_d   = estable_q ? '0 : hold_q;
      end
      PRESIONADO: begin
        hold_d   = hold_q + HW'(tick_i);
        largo_d  = hold_fin;
        corto_d  = !hold_fin && !estable_q;
        estado_d = (hold_fin && estable_q) ? SOSTENIDO :
                   (hold_fin || !estable_q) ? SUELTO : PRESIONADO;
      end
      SOSTENIDO: estado_d = estable_q ? SOSTENIDO : SUELTO;
      default:   estado_d = SUELTO;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q    <= '0;
      estable_q <= 1'b0;
      deb_q     <= '0;
      hold_q    <= '0;
      estado_q  <= SUELTO;
      corto_q   <= 1'b0;
      largo_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], boton_i ^ ACTIVO_BAJO};
      estable_q <= estable_d;
      deb_q     <= deb_d;
      hold_q    <= hold_d;
      estado_q  <= estado_d;
      corto_q   <= corto_d;
      largo_q   <= largo_d;
    end
  end
  assign nivel_o = estable_q;
  assign corto_o = corto_q;
  assign largo_o = largo_q;
endmodule

// File: rtl/boton_acondicionador.sv
// boton_acondicionador: shared ms prescaler feeding one debounce/press channel per button
module boton_acondicionador
  import boton_acondicionador_pkg::*;
#(
  parameter int NUM_BOTONES   = NUM_BOTONES_DEF,
  parameter int CICLOS_POR_MS = CICLOS_POR_MS_DEF,
  parameter int DEBOUNCE_MS   = DEBOUNCE_MS_DEF,
  parameter int HOLD_MS       = HOLD_MS_DEF,
  parameter bit ACTIVO_BAJO   = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BOTONES-1:0] botones_in,
  output logic [NUM_BOTONES-1:0] boton_nivel,
  output logic [NUM_BOTONES-1:0] pulso_corto,
  output logic [NUM_BOTONES-1:0] pulso_largo,
  output logic                   tick_ms
);
  localparam int PW = $clog2(CICLOS_POR_MS) + 1;
  logic [PW-1:0] pres_q, pres_d;
  assign tick_ms = pres_q == PW'(CICLOS_POR_MS - 1);
  always_comb pres_d = tick_ms ? '0 : pres_q + 1'b1;
  always_ff @(posedge clk) begin
    if (!reset) pres_q <= '0;
    else pres_q <= pres_d;
  end
  for (genvar i = 0; i < NUM_BOTONES; i++) begin : g_canal
    boton_canal #(
      .DEBOUNCE_MS(DEBOUNCE_MS),
      .HOLD_MS    (HOLD_MS),
      .ACTIVO_BAJO(ACTIVO_BAJO)
    ) u_canal (
      .clk    (clk),
      .reset  (reset),
      .tick_i (tick_ms),
      .boton_i(botones_in[i]),
      .nivel_o(boton_nivel[i]),
      .corto_o(pulso_corto[i]),
      .largo_o(pulso_largo[i])
    );
  end
endmodule
